// File: rtl/calc_res_dispatch_pkg.sv
// Shared types for the calc_res path feeding MipVram.
// Point record, screen bounds and channel geometry.
package calc_res_dispatch_pkg;

  localparam int NUM_CH       = 4;
  localparam int POS_W        = 10;
  localparam int DENS_W       = 8;
  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  typedef struct packed {
    logic [POS_W-1:0]  pos_x;
    logic [POS_W-1:0]  pos_y;
    logic [DENS_W-1:0] density;
  } calc_res_t;

  function automatic logic off_screen(
    input logic [POS_W-1:0] x,
    input logic [POS_W-1:0] y,
    input int               w,
    input int               h
  );
    return (int'(x) >= w) || (int'(y) >= h);
  endfunction

endpackage

// File: rtl/calc_res_fifo.sv
// Single-channel first-word-fall-through queue
// of calc_res_t records.
module calc_res_fifo
  import calc_res_dispatch_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      i_push,
  input  calc_res_t i_data,
  output logic      o_full,
  input  logic      i_pop,
  output logic      o_valid,
  output calc_res_t o_data
);

  localparam int AW = $clog2(DEPTH);

  calc_res_t      r_mem [DEPTH];
  logic [AW-1:0]  r_wr;
  logic [AW-1:0]  r_rd;
  logic [AW:0]    r_cnt;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_valid = (r_cnt != '0);
  assign o_data  = o_valid ? r_mem[r_rd] : '0;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & o_valid;

  // storage write at the tail
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  // pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/calc_res_dispatch.sv
// Classifies projected points, drops off-screen ones
// and steers the rest into four column-interleaved queues.
module calc_res_dispatch
  import calc_res_dispatch_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [POS_W-1:0]  io_in_pos_x,
  input  logic [POS_W-1:0]  io_in_pos_y,
  input  logic [DENS_W-1:0] io_in_density,
  output logic              io_calc_res_0_data_valid,
  input  logic              io_calc_res_0_rden,
  output logic [POS_W-1:0]  io_calc_res_0_screen_pos_x,
  output logic [POS_W-1:0]  io_calc_res_0_screen_pos_y,
  output logic [DENS_W-1:0] io_calc_res_0_density,
  output logic              io_calc_res_1_data_valid,
  input  logic              io_calc_res_1_rden,
  output logic [POS_W-1:0]  io_calc_res_1_screen_pos_x,
  output logic [POS_W-1:0]  io_calc_res_1_screen_pos_y,
  output logic [DENS_W-1:0] io_calc_res_1_density,
  output logic              io_calc_res_2_data_valid,
  input  logic              io_calc_res_2_rden,
  output logic [POS_W-1:0]  io_calc_res_2_screen_pos_x,
  output logic [POS_W-1:0]  io_calc_res_2_screen_pos_y,
  output logic [DENS_W-1:0] io_calc_res_2_density,
  output logic              io_calc_res_3_data_valid,
  input  logic              io_calc_res_3_rden,
  output logic [POS_W-1:0]  io_calc_res_3_screen_pos_x,
  output logic [POS_W-1:0]  io_calc_res_3_screen_pos_y,
  output logic [DENS_W-1:0] io_calc_res_3_density,
  output logic              io_busy,
  output logic [CNT_W-1:0]  io_drop_count
);

  logic              w_off;
  logic [1:0]        w_ch;
  logic              w_acc;
  calc_res_t         w_in;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_pop;
  logic [NUM_CH-1:0] w_valid;
  calc_res_t         w_head [NUM_CH];
  logic [CNT_W-1:0]  r_drop;

  assign w_off = off_screen(io_in_pos_x, io_in_pos_y,
                            SCREEN_W, SCREEN_H);
  assign w_ch  = io_in_pos_x[1:0];
  assign w_in  = '{pos_x:   io_in_pos_x,
                   pos_y:   io_in_pos_y,
                   density: io_in_density};

  // no pop bypass: a full lane stalls even if it is being drained
  assign io_in_ready = ~reset & (w_off | ~w_full[w_ch]);
  assign w_acc       = io_in_valid & io_in_ready;

  assign w_pop = {io_calc_res_3_rden, io_calc_res_2_rden,
                  io_calc_res_1_rden, io_calc_res_0_rden};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_push[g] = w_acc & ~w_off & (w_ch == 2'(g));
    calc_res_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock  (clock),
      .reset  (reset),
      .i_push (w_push[g]),
      .i_data (w_in),
      .o_full (w_full[g]),
      .i_pop  (w_pop[g]),
      .o_valid(w_valid[g]),
      .o_data (w_head[g])
    );
  end

  assign io_calc_res_0_data_valid   = w_valid[0];
  assign io_calc_res_0_screen_pos_x = w_head[0].pos_x;
  assign io_calc_res_0_screen_pos_y = w_head[0].pos_y;
  assign io_calc_res_0_density      = w_head[0].density;
  assign io_calc_res_1_data_valid   = w_valid[1];
  assign io_calc_res_1_screen_pos_x = w_head[1].pos_x;
  assign io_calc_res_1_screen_pos_y = w_head[1].pos_y;
  assign io_calc_res_1_density      = w_head[1].density;
  assign io_calc_res_2_data_valid   = w_valid[2];
  assign io_calc_res_2_screen_pos_x = w_head[2].pos_x;
  assign io_calc_res_2_screen_pos_y = w_head[2].pos_y;
  assign io_calc_res_2_density      = w_head[2].density;
  assign io_calc_res_3_data_valid   = w_valid[3];
  assign io_calc_res_3_screen_pos_x = w_head[3].pos_x;
  assign io_calc_res_3_screen_pos_y = w_head[3].pos_y;
  assign io_calc_res_3_density      = w_head[3].density;

  assign io_busy       = |w_valid;
  assign io_drop_count = r_drop;

  // saturating count of discarded off-screen points
  always_ff @(posedge clock) begin
    if (reset) begin
      r_drop <= '0;
    end else if (w_acc & w_off & ~&r_drop) begin
      r_drop <= r_drop + 1'b1;
    end
  end

endmodule

// File: tb/tb_calc_res_dispatch.sv
// Directed bench for calc_res_dispatch.
// Second instance uses a 4-bit drop counter for saturation.
module tb_calc_res_dispatch;

  logic       clock = 1'b0;
  logic       reset;
  logic       valid;
  logic [9:0] x;
  logic [9:0] y;
  logic [7:0] d;
  logic [3:0] rden;

  wire        ready;
  wire  [3:0] dv;
  wire  [9:0] px [4];
  wire  [9:0] py [4];
  wire  [7:0] pd [4];
  wire        busy;
  wire [15:0] drop;

  wire        s_ready;
  wire  [3:0] s_dv;
  wire  [9:0] s_px [4];
  wire  [9:0] s_py [4];
  wire  [7:0] s_pd [4];
  wire        s_busy;
  wire  [3:0] s_drop;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  calc_res_dispatch dut (
    .clock(clock), .reset(reset),
    .io_in_valid(valid), .io_in_ready(ready),
    .io_in_pos_x(x), .io_in_pos_y(y), .io_in_density(d),
    .io_calc_res_0_data_valid(dv[0]), .io_calc_res_0_rden(rden[0]),
    .io_calc_res_0_screen_pos_x(px[0]),
    .io_calc_res_0_screen_pos_y(py[0]),
    .io_calc_res_0_density(pd[0]),
    .io_calc_res_1_data_valid(dv[1]), .io_calc_res_1_rden(rden[1]),
    .io_calc_res_1_screen_pos_x(px[1]),
    .io_calc_res_1_screen_pos_y(py[1]),
    .io_calc_res_1_density(pd[1]),
    .io_calc_res_2_data_valid(dv[2]), .io_calc_res_2_rden(rden[2]),
    .io_calc_res_2_screen_pos_x(px[2]),
    .io_calc_res_2_screen_pos_y(py[2]),
    .io_calc_res_2_density(pd[2]),
    .io_calc_res_3_data_valid(dv[3]), .io_calc_res_3_rden(rden[3]),
    .io_calc_res_3_screen_pos_x(px[3]),
    .io_calc_res_3_screen_pos_y(py[3]),
    .io_calc_res_3_density(pd[3]),
    .io_busy(busy), .io_drop_count(drop)
  );

  calc_res_dispatch #(.CNT_W(4)) sat (
    .clock(clock), .reset(reset),
    .io_in_valid(valid), .io_in_ready(s_ready),
    .io_in_pos_x(x), .io_in_pos_y(y), .io_in_density(d),
    .io_calc_res_0_data_valid(s_dv[0]), .io_calc_res_0_rden(rden[0]),
    .io_calc_res_0_screen_pos_x(s_px[0]),
    .io_calc_res_0_screen_pos_y(s_py[0]),
    .io_calc_res_0_density(s_pd[0]),
    .io_calc_res_1_data_valid(s_dv[1]), .io_calc_res_1_rden(rden[1]),
    .io_calc_res_1_screen_pos_x(s_px[1]),
    .io_calc_res_1_screen_pos_y(s_py[1]),
    .io_calc_res_1_density(s_pd[1]),
    .io_calc_res_2_data_valid(s_dv[2]), .io_calc_res_2_rden(rden[2]),
    .io_calc_res_2_screen_pos_x(s_px[2]),
    .io_calc_res_2_screen_pos_y(s_py[2]),
    .io_calc_res_2_density(s_pd[2]),
    .io_calc_res_3_data_valid(s_dv[3]), .io_calc_res_3_rden(rden[3]),
    .io_calc_res_3_screen_pos_x(s_px[3]),
    .io_calc_res_3_screen_pos_y(s_py[3]),
    .io_calc_res_3_density(s_pd[3]),
    .io_busy(s_busy), .io_drop_count(s_drop)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int px_i, input int py_i,
                     input int d_i);
    x = 10'(px_i);
    y = 10'(py_i);
    d = 8'(d_i);
  endtask

  initial begin
    reset = 1'b1;
    valid = 1'b0;
    rden  = '0;
    put(5, 7, 32'h20);
    tick();
    valid = 1'b1;
    #1;
    chk("ready_in_reset", ready, 0);
    tick();
    reset = 1'b0;
    valid = 1'b0;
    #1;
    chk("rst_dv", dv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop, 0);
    chk("rst_px1_zero", px[1], 0);
    chk("rst_ready", ready, 1);

    // single point into lane 1
    valid = 1'b1;
    #1;
    chk("p1_ready", ready, 1);
    tick();
    valid = 1'b0;
    chk("p1_dv", dv, 4'b0010);
    chk("p1_x", px[1], 5);
    chk("p1_y", py[1], 7);
    chk("p1_d", pd[1], 32'h20);
    chk("p1_busy", busy, 1);
    rden[1] = 1'b1;
    tick();
    rden[1] = 1'b0;
    chk("p1_pop_dv", dv, 0);
    chk("p1_pop_busy", busy, 0);
    chk("p1_pop_x0", px[1], 0);

    // fill lane 0
    valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      put(4 * i, i, i);
      #1;
      chk("fill_ready", ready, 1);
      tick();
    end
    put(64, 16, 16);
    #1;
    chk("full_ready", ready, 0);
    chk("full_head", px[0], 0);
    rden[0] = 1'b1;
    tick();
    rden[0] = 1'b0;
    #1;
    chk("after_pop_ready", ready, 1);
    chk("after_pop_head", px[0], 4);
    tick();
    valid = 1'b0;
    put(68, 0, 0);
    #1;
    chk("refull_ready", ready, 0);
    for (int k = 1; k <= 16; k++) begin
      chk("drain_x", px[0], 4 * k);
      chk("drain_y", py[0], k);
      rden[0] = 1'b1;
      tick();
    end
    rden[0] = 1'b0;
    chk("drain_empty", dv[0], 0);

    // off-screen drops and corner point
    valid = 1'b1;
    put(640, 0, 1);
    #1;
    chk("drop_ready", ready, 1);
    tick();
    put(0, 480, 2);
    tick();
    put(1023, 1023, 3);
    tick();
    valid = 1'b0;
    chk("drop_count", drop, 3);
    chk("drop_no_dv", dv, 0);
    valid = 1'b1;
    put(639, 479, 32'h55);
    tick();
    valid = 1'b0;
    chk("corner_dv", dv, 4'b1000);
    chk("corner_x", px[3], 639);
    chk("corner_y", py[3], 479);
    chk("corner_d", pd[3], 32'h55);
    rden[3] = 1'b1;
    tick();
    rden[3] = 1'b0;
    chk("corner_pop", dv, 0);

    // streaming lane 2 with concurrent drain
    rden[2] = 1'b1;
    valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      put(2 + 4 * i, i, 32'h80 + i);
      #1;
      chk("stream_ready", ready, 1);
      tick();
      chk("stream_dv", dv, 4'b0100);
      chk("stream_x", px[2], 2 + 4 * i);
    end
    put(22, 5, 5);
    reset = 1'b1;
    #1;
    chk("stream_rst_ready", ready, 0);
    tick();
    reset   = 1'b0;
    valid   = 1'b0;
    rden[2] = 1'b0;
    #1;
    chk("mid_rst_dv", dv, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_drop", drop, 0);

    // saturation on the 4-bit counter
    valid = 1'b1;
    put(700, 0, 0);
    repeat (20) tick();
    valid = 1'b0;
    chk("sat_drop4", s_drop, 15);
    chk("sat_drop16", drop, 20);
    chk("sat_no_dv", s_dv, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
